// File: rtl/mon_trace_capture_if.sv
// Trace record stream: valid/ready handshake carrying {ts, chg_mask, values}.
// Backpressure: the producer holds rec_data stable while rec_valid && !rec_ready.
interface mon_trace_capture_if #(
  parameter int REC_W = 22
);
  logic             rec_valid;
  logic             rec_ready;
  logic [REC_W-1:0] rec_data;

  modport master (output rec_valid, output rec_data, input rec_ready);
  modport slave  (input rec_valid, input rec_data, output rec_ready);
endinterface

// File: rtl/mon_trace_capture.sv
// Multi-channel probe monitor: time-stamped change/strobe/shot records into a FIFO.
// Latency: 1 cycle from sampling edge to rec_valid (empty FIFO); a full FIFO drops and counts.
module mon_trace_capture #(
  parameter int NCH   = 3,
  parameter int CW    = 1,
  parameter int DEPTH = 16,
  parameter int TS_W  = 16
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic [1:0]                   mode,
  input  logic [NCH-1:0]               ch_en,
  input  logic [15:0]                  stb_period,
  input  logic [NCH*CW-1:0]            probe,
  input  logic                         clr_ovf,
  mon_trace_capture_if.master          rec,
  output logic [$clog2(DEPTH+1)-1:0]   fifo_level,
  output logic                         overflow,
  output logic [15:0]                  drop_cnt
);
  localparam int REC_W = TS_W + NCH + NCH * CW;
  localparam int AW    = $clog2(DEPTH);
  localparam int LW    = $clog2(DEPTH + 1);

  typedef enum logic [1:0] {
    M_OFF  = 2'b00,
    M_MON  = 2'b01,
    M_STB  = 2'b10,
    M_SHOT = 2'b11
  } mode_e;

  logic [TS_W-1:0]   ts_q, ts_d;
  logic [NCH*CW-1:0] last_q, last_d;
  logic              first_q, first_d;
  logic [1:0]        prev_mode_q, prev_mode_d;
  logic [15:0]       stb_cnt_q, stb_cnt_d;
  logic              shot_done_q, shot_done_d;
  logic [REC_W-1:0]  mem_q [DEPTH];
  logic [REC_W-1:0]  mem_d [DEPTH];
  logic [AW-1:0]     wr_q, wr_d, rd_q, rd_d;
  logic [LW-1:0]     count_q, count_d;
  logic              overflow_q, overflow_d;
  logic [15:0]       drop_cnt_q, drop_cnt_d;

  logic [NCH*CW-1:0] vals;
  logic [NCH-1:0]    diff, chg;
  logic [15:0]       per_eff;
  logic              entry, push, pop, full, push_ok, drop;
  logic [REC_W-1:0]  rec_in;

  // Sampling: decide whether this edge produces a record and what it holds.
  always_comb begin
    vals        = '0;
    diff        = '0;
    for (int i = 0; i < NCH; i++) begin
      if (ch_en[i]) vals[i*CW +: CW] = probe[i*CW +: CW];
      diff[i] = (probe[i*CW +: CW] != last_q[i*CW +: CW]);
    end
    entry       = first_q || (mode != prev_mode_q);
    per_eff     = (stb_period == 16'd0) ? 16'd1 : stb_period;
    push        = 1'b0;
    chg         = diff & ch_en;
    stb_cnt_d   = stb_cnt_q;
    shot_done_d = 1'b0;
    case (mode)
      M_MON: begin
        push = entry || (|(diff & ch_en));
        if (entry) chg = ch_en;
      end
      M_STB: begin
        if (entry || (stb_cnt_q >= per_eff)) begin
          push      = 1'b1;
          stb_cnt_d = 16'd1;
        end else begin
          stb_cnt_d = stb_cnt_q + 16'd1;
        end
      end
      M_SHOT: begin
        push        = !shot_done_q;
        shot_done_d = 1'b1;
        chg         = ch_en;
      end
      default: ;
    endcase
    if (ch_en == '0) push = 1'b0;
    rec_in      = {ts_q, chg, vals};
    ts_d        = ts_q + TS_W'(1);
    last_d      = probe;
    first_d     = 1'b0;
    prev_mode_d = mode;
  end

  // Record FIFO: never overwrites; a push into a full FIFO without a pop is dropped.
  always_comb begin
    pop     = (count_q != '0) && rec.rec_ready;
    full    = (count_q == LW'(DEPTH));
    push_ok = push && (!full || pop);
    drop    = push && full && !pop;
    mem_d   = mem_q;
    wr_d    = wr_q;
    rd_d    = rd_q;
    if (push_ok) begin
      mem_d[wr_q] = rec_in;
      wr_d        = wr_q + AW'(1);
    end
    if (pop) rd_d = rd_q + AW'(1);
    count_d    = count_q + LW'(push_ok) - LW'(pop);
    overflow_d = overflow_q;
    drop_cnt_d = drop_cnt_q;
    // A drop on the same edge as a clear wins: the clear applies first, then the drop counts.
    if (drop) begin
      overflow_d = 1'b1;
      if (clr_ovf)                     drop_cnt_d = 16'd1;
      else if (drop_cnt_q != 16'hFFFF) drop_cnt_d = drop_cnt_q + 16'd1;
    end else if (clr_ovf) begin
      overflow_d = 1'b0;
      drop_cnt_d = 16'd0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ts_q        <= '0;
      last_q      <= '0;
      first_q     <= 1'b1;
      prev_mode_q <= 2'b00;
      stb_cnt_q   <= 16'd1;
      shot_done_q <= 1'b0;
      wr_q        <= '0;
      rd_q        <= '0;
      count_q     <= '0;
      overflow_q  <= 1'b0;
      drop_cnt_q  <= 16'd0;
    end else begin
      ts_q        <= ts_d;
      last_q      <= last_d;
      first_q     <= first_d;
      prev_mode_q <= prev_mode_d;
      stb_cnt_q   <= stb_cnt_d;
      shot_done_q <= shot_done_d;
      wr_q        <= wr_d;
      rd_q        <= rd_d;
      count_q     <= count_d;
      overflow_q  <= overflow_d;
      drop_cnt_q  <= drop_cnt_d;
    end
  end

  always_ff @(posedge clk) begin
    mem_q <= mem_d;
  end

  assign rec.rec_valid = (count_q != '0);
  assign rec.rec_data  = (count_q != '0) ? mem_q[rd_q] : '0;
  assign fifo_level    = count_q;
  assign overflow      = overflow_q;
  assign drop_cnt      = drop_cnt_q;
endmodule

// File: tb/tb_mon_trace_capture.sv
// Scoreboard bench for mon_trace_capture: expected records queued at stimulus, compared on drain.
module tb_mon_trace_capture;
  logic        clk = 1'b0;
  logic        rst;
  logic [1:0]  mode;
  logic [2:0]  ch_en;
  logic [15:0] stb_period;
  logic [2:0]  probe;
  logic        clr_ovf;
  logic [4:0]  fifo_level;
  logic        overflow;
  logic [15:0] drop_cnt;

  logic [15:0] exp_ts;
  logic [21:0] exp_q[$];
  logic [21:0] want;
  int checks = 0;
  int errors = 0;

  mon_trace_capture_if #(.REC_W(22)) rif ();

  mon_trace_capture #(.NCH(3), .CW(1), .DEPTH(16), .TS_W(16)) dut (
    .clk        (clk),
    .rst        (rst),
    .mode       (mode),
    .ch_en      (ch_en),
    .stb_period (stb_period),
    .probe      (probe),
    .clr_ovf    (clr_ovf),
    .rec        (rif.master),
    .fifo_level (fifo_level),
    .overflow   (overflow),
    .drop_cnt   (drop_cnt)
  );

  always #5 clk = ~clk;

  // Reference timestamp: value the DUT will stamp at the next rising edge.
  always @(posedge clk) exp_ts <= rst ? 16'd0 : exp_ts + 16'd1;

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic test_reset;
    rst = 1'b1; mode = 2'b00; ch_en = 3'b000; stb_period = 16'd0;
    probe = 3'b000; clr_ovf = 1'b0; rif.rec_ready = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    checks++; if (rif.rec_valid !== 1'b0) begin errors++; $display("FAIL reset_valid got=%b exp=0", rif.rec_valid); end
    checks++; if (rif.rec_data !== 22'd0) begin errors++; $display("FAIL reset_data got=%h exp=0", rif.rec_data); end
    checks++; if (fifo_level !== 5'd0) begin errors++; $display("FAIL reset_level got=%0d exp=0", fifo_level); end
    checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL reset_ovf got=%b exp=0", overflow); end
    checks++; if (drop_cnt !== 16'd0) begin errors++; $display("FAIL reset_drop got=%0d exp=0", drop_cnt); end
  endtask

  task automatic test_monitor_entry;
    tick(2);
    ch_en = 3'b111; mode = 2'b01;
    exp_q.push_back({16'd2, 3'b111, 3'b000});
    tick(1);
    checks++; if (rif.rec_valid !== 1'b1) begin errors++; $display("FAIL entry_latency got=%b exp=1", rif.rec_valid); end
    checks++; if (fifo_level !== 5'd1) begin errors++; $display("FAIL entry_level got=%0d exp=1", fifo_level); end
    rif.rec_ready = 1'b1;
    for (int c = 0; c < 40 && exp_q.size() > 0; c++) begin
      if (rif.rec_valid) begin
        want = exp_q.pop_front(); checks++;
        if (rif.rec_data !== want) begin errors++; $display("FAIL entry_rec got=%h exp=%h", rif.rec_data, want); end
      end
      @(negedge clk);
    end
    rif.rec_ready = 1'b0;
    checks++; if (exp_q.size() != 0 || rif.rec_valid !== 1'b0) begin errors++; $display("FAIL entry_drain left=%0d valid=%b exp=0/0", exp_q.size(), rif.rec_valid); end
  endtask

  task automatic test_monitor_change;
    for (int i = 0; i < 100 && exp_ts != 16'd10; i++) tick(1);
    probe = 3'b010;
    exp_q.push_back({16'd10, 3'b010, 3'b010});
    for (int i = 0; i < 100 && exp_ts != 16'd20; i++) tick(1);
    probe = 3'b001;
    exp_q.push_back({16'd20, 3'b011, 3'b001});
    tick(1);
    checks++; if (fifo_level !== 5'd2) begin errors++; $display("FAIL mon_level got=%0d exp=2", fifo_level); end
    rif.rec_ready = 1'b1;
    for (int c = 0; c < 40 && exp_q.size() > 0; c++) begin
      if (rif.rec_valid) begin
        want = exp_q.pop_front(); checks++;
        if (rif.rec_data !== want) begin errors++; $display("FAIL mon_rec got=%h exp=%h", rif.rec_data, want); end
      end
      @(negedge clk);
    end
    rif.rec_ready = 1'b0;
    checks++; if (exp_q.size() != 0 || rif.rec_valid !== 1'b0) begin errors++; $display("FAIL mon_drain left=%0d valid=%b exp=0/0", exp_q.size(), rif.rec_valid); end
  endtask

  task automatic test_strobe;
    logic [15:0] t0;
    t0 = exp_ts; stb_period = 16'd4; mode = 2'b10;
    for (int k = 0; k < 4; k++) exp_q.push_back({t0 + 16'(4 * k), 3'b000, 3'b001});
    tick(13);
    mode = 2'b00;
    checks++; if (fifo_level !== 5'd4) begin errors++; $display("FAIL strobe4_level got=%0d exp=4", fifo_level); end
    tick(1);
    t0 = exp_ts; stb_period = 16'd0; mode = 2'b10;
    for (int k = 0; k < 5; k++) exp_q.push_back({t0 + 16'(k), 3'b000, 3'b001});
    tick(5);
    mode = 2'b00;
    checks++; if (fifo_level !== 5'd9) begin errors++; $display("FAIL strobe0_level got=%0d exp=9", fifo_level); end
    rif.rec_ready = 1'b1;
    for (int c = 0; c < 40 && exp_q.size() > 0; c++) begin
      if (rif.rec_valid) begin
        want = exp_q.pop_front(); checks++;
        if (rif.rec_data !== want) begin errors++; $display("FAIL strobe_rec got=%h exp=%h", rif.rec_data, want); end
      end
      @(negedge clk);
    end
    rif.rec_ready = 1'b0;
    checks++; if (exp_q.size() != 0 || rif.rec_valid !== 1'b0) begin errors++; $display("FAIL strobe_drain left=%0d valid=%b exp=0/0", exp_q.size(), rif.rec_valid); end
  endtask

  task automatic test_shot;
    probe = 3'b110; mode = 2'b11;
    exp_q.push_back({exp_ts, 3'b111, 3'b110});
    tick(10);
    checks++; if (fifo_level !== 5'd1) begin errors++; $display("FAIL shot_hold_level got=%0d exp=1", fifo_level); end
    mode = 2'b00; tick(1);
    mode = 2'b11;
    exp_q.push_back({exp_ts, 3'b111, 3'b110});
    tick(3);
    checks++; if (fifo_level !== 5'd2) begin errors++; $display("FAIL shot_reentry_level got=%0d exp=2", fifo_level); end
    mode = 2'b00;
    rif.rec_ready = 1'b1;
    for (int c = 0; c < 40 && exp_q.size() > 0; c++) begin
      if (rif.rec_valid) begin
        want = exp_q.pop_front(); checks++;
        if (rif.rec_data !== want) begin errors++; $display("FAIL shot_rec got=%h exp=%h", rif.rec_data, want); end
      end
      @(negedge clk);
    end
    rif.rec_ready = 1'b0;
    checks++; if (exp_q.size() != 0 || rif.rec_valid !== 1'b0) begin errors++; $display("FAIL shot_drain left=%0d valid=%b exp=0/0", exp_q.size(), rif.rec_valid); end
  endtask

  task automatic test_chen;
    ch_en = 3'b101; mode = 2'b01;
    exp_q.push_back({exp_ts, 3'b101, 3'b100});
    tick(1);
    probe = 3'b100;
    tick(1);
    probe = 3'b101;
    exp_q.push_back({exp_ts, 3'b001, 3'b101});
    tick(1);
    checks++; if (fifo_level !== 5'd2) begin errors++; $display("FAIL chen_mask_level got=%0d exp=2", fifo_level); end
    ch_en = 3'b000; mode = 2'b10; tick(2);
    mode = 2'b11; tick(2);
    mode = 2'b01; probe = 3'b010; tick(2);
    checks++; if (fifo_level !== 5'd2) begin errors++; $display("FAIL chen_zero_level got=%0d exp=2", fifo_level); end
    mode = 2'b00; ch_en = 3'b111;
    rif.rec_ready = 1'b1;
    for (int c = 0; c < 40 && exp_q.size() > 0; c++) begin
      if (rif.rec_valid) begin
        want = exp_q.pop_front(); checks++;
        if (rif.rec_data !== want) begin errors++; $display("FAIL chen_rec got=%h exp=%h", rif.rec_data, want); end
      end
      @(negedge clk);
    end
    rif.rec_ready = 1'b0;
    checks++; if (exp_q.size() != 0 || rif.rec_valid !== 1'b0) begin errors++; $display("FAIL chen_drain left=%0d valid=%b exp=0/0", exp_q.size(), rif.rec_valid); end
  endtask

  task automatic test_overflow;
    logic [2:0] prev, nxt;
    int n;
    prev = probe; n = 0;
    mode = 2'b01;
    exp_q.push_back({exp_ts, 3'b111, prev}); n++;
    tick(1);
    for (int i = 1; i < 20; i++) begin
      nxt = 3'(i);
      probe = nxt;
      if (n < 16) exp_q.push_back({exp_ts, nxt ^ prev, nxt});
      n++; prev = nxt;
      tick(1);
    end
    checks++; if (fifo_level !== 5'd16) begin errors++; $display("FAIL ovf_level got=%0d exp=16", fifo_level); end
    checks++; if (overflow !== 1'b1) begin errors++; $display("FAIL ovf_flag got=%b exp=1", overflow); end
    checks++; if (drop_cnt !== 16'd4) begin errors++; $display("FAIL ovf_drop got=%0d exp=4", drop_cnt); end
    checks++; if (rif.rec_data !== exp_q[0]) begin errors++; $display("FAIL ovf_head got=%h exp=%h", rif.rec_data, exp_q[0]); end
    tick(1);
    checks++; if (rif.rec_data !== exp_q[0]) begin errors++; $display("FAIL ovf_stall_stable got=%h exp=%h", rif.rec_data, exp_q[0]); end
    rif.rec_ready = 1'b1; nxt = ~prev; probe = nxt;
    want = exp_q.pop_front(); checks++;
    if (rif.rec_data !== want) begin errors++; $display("FAIL ovf_popfull_rec got=%h exp=%h", rif.rec_data, want); end
    exp_q.push_back({exp_ts, 3'b111, nxt});
    tick(1);
    rif.rec_ready = 1'b0;
    checks++; if (fifo_level !== 5'd16) begin errors++; $display("FAIL ovf_popfull_level got=%0d exp=16", fifo_level); end
    checks++; if (drop_cnt !== 16'd4) begin errors++; $display("FAIL ovf_popfull_drop got=%0d exp=4", drop_cnt); end
    mode = 2'b00;
    rif.rec_ready = 1'b1;
    for (int c = 0; c < 40 && exp_q.size() > 0; c++) begin
      if (rif.rec_valid) begin
        want = exp_q.pop_front(); checks++;
        if (rif.rec_data !== want) begin errors++; $display("FAIL ovf_rec got=%h exp=%h", rif.rec_data, want); end
      end
      @(negedge clk);
    end
    rif.rec_ready = 1'b0;
    checks++; if (exp_q.size() != 0 || rif.rec_valid !== 1'b0) begin errors++; $display("FAIL ovf_drain left=%0d valid=%b exp=0/0", exp_q.size(), rif.rec_valid); end
  endtask

  task automatic test_clr_ovf;
    clr_ovf = 1'b1; tick(1); clr_ovf = 1'b0;
    checks++; if (overflow !== 1'b0 || drop_cnt !== 16'd0) begin errors++; $display("FAIL clr_plain got=%b/%0d exp=0/0", overflow, drop_cnt); end
    mode = 2'b01; tick(1);
    for (int i = 0; i < 16; i++) begin probe = probe ^ 3'b001; tick(1); end
    checks++; if (overflow !== 1'b1 || drop_cnt !== 16'd1) begin errors++; $display("FAIL clr_fill got=%b/%0d exp=1/1", overflow, drop_cnt); end
    probe = probe ^ 3'b001; clr_ovf = 1'b1; tick(1);
    checks++; if (overflow !== 1'b1 || drop_cnt !== 16'd1) begin errors++; $display("FAIL clr_vs_drop got=%b/%0d exp=1/1", overflow, drop_cnt); end
    tick(1); clr_ovf = 1'b0;
    checks++; if (overflow !== 1'b0 || drop_cnt !== 16'd0) begin errors++; $display("FAIL clr_after got=%b/%0d exp=0/0", overflow, drop_cnt); end
    mode = 2'b00; rst = 1'b1; tick(1); rst = 1'b0;
    checks++; if (fifo_level !== 5'd0) begin errors++; $display("FAIL clr_flush_level got=%0d exp=0", fifo_level); end
  endtask

  task automatic test_reset_flush;
    ch_en = 3'b111; mode = 2'b01; tick(1);
    for (int i = 0; i < 4; i++) begin probe = probe ^ 3'b100; tick(1); end
    checks++; if (fifo_level !== 5'd5) begin errors++; $display("FAIL flush_pre_level got=%0d exp=5", fifo_level); end
    rst = 1'b1; tick(1);
    checks++; if (rif.rec_valid !== 1'b0 || fifo_level !== 5'd0) begin errors++; $display("FAIL flush_post got=%b/%0d exp=0/0", rif.rec_valid, fifo_level); end
    checks++; if (rif.rec_data !== 22'd0) begin errors++; $display("FAIL flush_data got=%h exp=0", rif.rec_data); end
    rst = 1'b0; rif.rec_ready = 1'b1;
    exp_q.push_back({16'd0, 3'b111, probe});
    tick(1);
    checks++; if (rif.rec_valid !== 1'b1 || fifo_level !== 5'd1) begin errors++; $display("FAIL flush_entry got=%b/%0d exp=1/1", rif.rec_valid, fifo_level); end
    want = exp_q.pop_front(); checks++;
    if (rif.rec_data !== want) begin errors++; $display("FAIL flush_entry_rec got=%h exp=%h", rif.rec_data, want); end
    tick(1);
    checks++; if (rif.rec_valid !== 1'b0 || fifo_level !== 5'd0) begin errors++; $display("FAIL flush_popped got=%b/%0d exp=0/0", rif.rec_valid, fifo_level); end
    rif.rec_ready = 1'b0; mode = 2'b00;
  endtask

  initial begin
    test_reset();
    test_monitor_entry();
    test_monitor_change();
    test_strobe();
    test_shot();
    test_chen();
    test_overflow();
    test_clr_ovf();
    test_reset_flush();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
